// File: rtl/instr_decode.sv
// Byte-serial x86-subset instruction decoder.
// Consumes one instruction byte per clock: prefixes, opcode, ModR/M, SIB,
// displacement and immediate, then presents the decoded fields until the
// downstream stage takes them.
module instr_decode #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned MAX_INSTR_WIDTH = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_res_valid,
  input  logic [MAX_INSTR_WIDTH-1:0] i_instr,
  input  logic [3:0]                 i_instr_len,
  input  logic [ADDRESS_WIDTH-1:0]   i_pc,
  output logic                       o_dec_ready,
  output logic                       o_valid,
  input  logic                       i_ex_ready,
  output logic [ADDRESS_WIDTH-1:0]   o_pc,
  output logic [ADDRESS_WIDTH-1:0]   o_next_pc,
  output logic [7:0]                 o_opcode,
  output logic [7:0]                 o_prefix,
  output logic [1:0]                 o_fmt,
  output logic [7:0]                 o_modrm,
  output logic [7:0]                 o_sib,
  output logic [31:0]                o_disp,
  output logic [31:0]                o_imm,
  output logic                       o_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PFX_OP = 3'd1;
  localparam logic [2:0] MODRM  = 3'd2;
  localparam logic [2:0] SIB    = 3'd3;
  localparam logic [2:0] DISP   = 3'd4;
  localparam logic [2:0] IMM    = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]                 state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [3:0]                 len_q, len_d;
  logic [MAX_INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]                 opcode_q, opcode_d;
  logic [7:0]                 prefix_q, prefix_d;
  logic [1:0]                 fmt_q, fmt_d;
  logic [7:0]                 modrm_q, modrm_d;
  logic [7:0]                 sib_q, sib_d;
  logic [31:0]                disp_q, disp_d;
  logic [31:0]                imm_q, imm_d;
  logic                       err_q, err_d;
  // Field lengths in bytes (0 = absent) and bytes gathered so far.
  logic [2:0]                 disp_len_q, disp_len_d;
  logic [2:0]                 disp_cnt_q, disp_cnt_d;
  logic [2:0]                 imm_len_q, imm_len_d;
  logic [2:0]                 imm_cnt_q, imm_cnt_d;

  logic [7:0]                 cur_byte;
  logic [2:0]                 nxt;
  logic                       err_set;
  logic                       consume;
  logic [2:0]                 imm_wide;
  logic [31:0]                disp_asm;
  logic [31:0]                imm_asm;

  // Sign-extend a little-endian field of n bytes to 32 bits.
  function automatic logic [31:0] sext(input logic [31:0] v, input logic [2:0] n);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{v[7]}}, v[7:0]};
      3'd2:    r = {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Stage that follows the addressing bytes.
  function automatic logic [2:0] after_addr(input logic [2:0] dlen, input logic [2:0] ilen);
    logic [2:0] r;
    if (dlen != 3'd0) begin
      r = DISP;
    end else if (ilen != 3'd0) begin
      r = IMM;
    end else begin
      r = DONE;
    end
    return r;
  endfunction

  // Select the instruction byte at the current index.
  always_comb begin
    cur_byte = 8'h00;
    for (int unsigned b = 0; b < MAX_INSTR_WIDTH / 8; b++) begin
      if (idx_q == 4'(b)) begin
        cur_byte = instr_q[b*8 +: 8];
      end
    end
  end

  // Next-state and field-update logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    prefix_d   = prefix_q;
    fmt_d      = fmt_q;
    modrm_d    = modrm_q;
    sib_d      = sib_q;
    disp_d     = disp_q;
    imm_d      = imm_q;
    err_d      = err_q;
    disp_len_d = disp_len_q;
    disp_cnt_d = disp_cnt_q;
    imm_len_d  = imm_len_q;
    imm_cnt_d  = imm_cnt_q;
    nxt        = DONE;
    err_set    = 1'b0;
    consume    = 1'b0;
    disp_asm   = disp_q;
    imm_asm    = imm_q;
    imm_wide   = prefix_q[3] ? 3'd2 : 3'd4;

    case (state_q)
      IDLE: begin
        if (i_res_valid) begin
          instr_d    = i_instr;
          len_d      = i_instr_len;
          pc_d       = i_pc;
          idx_d      = 4'd0;
          opcode_d   = 8'h00;
          prefix_d   = 8'h00;
          fmt_d      = 2'b00;
          modrm_d    = 8'h00;
          sib_d      = 8'h00;
          disp_d     = 32'h0;
          imm_d      = 32'h0;
          err_d      = 1'b0;
          disp_len_d = 3'd0;
          disp_cnt_d = 3'd0;
          imm_len_d  = 3'd0;
          imm_cnt_d  = 3'd0;
          state_d    = PFX_OP;
        end
      end

      PFX_OP: begin
        consume = 1'b1;
        nxt     = PFX_OP;
        case (cur_byte)
          8'hF0: prefix_d[0]   = 1'b1;
          8'hF3: prefix_d[1]   = 1'b1;
          8'hF2: prefix_d[2]   = 1'b1;
          8'h66: prefix_d[3]   = 1'b1;
          8'h67: prefix_d[4]   = 1'b1;
          8'h26: prefix_d[7:5] = 3'd1;
          8'h2E: prefix_d[7:5] = 3'd2;
          8'h36: prefix_d[7:5] = 3'd3;
          8'h3E: prefix_d[7:5] = 3'd4;
          8'h64: prefix_d[7:5] = 3'd5;
          8'h65: prefix_d[7:5] = 3'd6;
          default: begin
            opcode_d = cur_byte;
            nxt      = DONE;
            if (cur_byte[7:6] == 2'b00) begin
              // ALU block: r/m forms, accumulator-immediate forms, misc.
              unique case (cur_byte[2:1])
                2'b00, 2'b01: nxt = MODRM;
                2'b10: begin
                  nxt       = IMM;
                  imm_len_d = cur_byte[0] ? imm_wide : 3'd1;
                end
                default: nxt = DONE;
              endcase
            end else if ((cur_byte[7:5] == 3'b010) || (cur_byte[7:3] == 5'b10010) ||
                         (cur_byte == 8'hC3) || (cur_byte == 8'hF4)) begin
              nxt = DONE;
            end else if (cur_byte[7:2] == 6'b100010) begin
              nxt = MODRM;
            end else if ((cur_byte == 8'h80) || (cur_byte == 8'h83)) begin
              nxt       = MODRM;
              imm_len_d = 3'd1;
            end else if (cur_byte == 8'h81) begin
              nxt       = MODRM;
              imm_len_d = imm_wide;
            end else if ((cur_byte[7:3] == 5'b10110) || (cur_byte == 8'h6A) ||
                         (cur_byte == 8'hEB)) begin
              nxt       = IMM;
              imm_len_d = 3'd1;
            end else if ((cur_byte[7:3] == 5'b10111) || (cur_byte == 8'h68) ||
                         (cur_byte == 8'hE8) || (cur_byte == 8'hE9)) begin
              nxt       = IMM;
              imm_len_d = imm_wide;
            end else begin
              err_set = 1'b1;
            end
          end
        endcase
      end

      MODRM: begin
        consume    = 1'b1;
        modrm_d    = cur_byte;
        fmt_d[0]   = 1'b1;
        disp_len_d = 3'd0;
        unique case (cur_byte[7:6])
          2'b00:   disp_len_d = (cur_byte[2:0] == 3'b101) ? 3'd4 : 3'd0;
          2'b01:   disp_len_d = 3'd1;
          2'b10:   disp_len_d = 3'd4;
          default: disp_len_d = 3'd0;
        endcase
        if ((cur_byte[7:6] != 2'b11) && (cur_byte[2:0] == 3'b100)) begin
          nxt = SIB;
        end else begin
          nxt = after_addr(disp_len_d, imm_len_q);
        end
      end

      SIB: begin
        consume  = 1'b1;
        sib_d    = cur_byte;
        fmt_d[1] = 1'b1;
        // No-base form: base=101 under mod=00 carries a disp32.
        if ((modrm_q[7:6] == 2'b00) && (cur_byte[2:0] == 3'b101)) begin
          disp_len_d = 3'd4;
        end
        nxt = after_addr(disp_len_d, imm_len_q);
      end

      DISP: begin
        consume = 1'b1;
        disp_asm[{disp_cnt_q[1:0], 3'b000} +: 8] = cur_byte;
        disp_cnt_d = disp_cnt_q + 3'd1;
        if (disp_cnt_d == disp_len_q) begin
          disp_d = sext(disp_asm, disp_len_q);
          nxt    = (imm_len_q != 3'd0) ? IMM : DONE;
        end else begin
          disp_d = disp_asm;
          nxt    = DISP;
        end
      end

      IMM: begin
        consume = 1'b1;
        imm_asm[{imm_cnt_q[1:0], 3'b000} +: 8] = cur_byte;
        imm_cnt_d = imm_cnt_q + 3'd1;
        if (imm_cnt_d == imm_len_q) begin
          imm_d = sext(imm_asm, imm_len_q);
          nxt   = DONE;
        end else begin
          imm_d = imm_asm;
          nxt   = IMM;
        end
      end

      DONE: begin
        if (i_ex_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Common byte-consumption bookkeeping and length checking.
    if (consume) begin
      idx_d = idx_q + 4'd1;
      if (nxt == DONE) begin
        state_d = DONE;
        if (err_set || (idx_d != len_q)) begin
          err_d = 1'b1;
        end
      end else if (idx_d >= len_q) begin
        // Ran out of claimed bytes mid-instruction.
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        state_d = nxt;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      len_q      <= 4'd0;
      instr_q    <= '0;
      pc_q       <= '0;
      opcode_q   <= 8'h00;
      prefix_q   <= 8'h00;
      fmt_q      <= 2'b00;
      modrm_q    <= 8'h00;
      sib_q      <= 8'h00;
      disp_q     <= 32'h0;
      imm_q      <= 32'h0;
      err_q      <= 1'b0;
      disp_len_q <= 3'd0;
      disp_cnt_q <= 3'd0;
      imm_len_q  <= 3'd0;
      imm_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      prefix_q   <= prefix_d;
      fmt_q      <= fmt_d;
      modrm_q    <= modrm_d;
      sib_q      <= sib_d;
      disp_q     <= disp_d;
      imm_q      <= imm_d;
      err_q      <= err_d;
      disp_len_q <= disp_len_d;
      disp_cnt_q <= disp_cnt_d;
      imm_len_q  <= imm_len_d;
      imm_cnt_q  <= imm_cnt_d;
    end
  end

  // Index equals bytes consumed once in DONE, so next_pc is pc + index.
  assign o_dec_ready = reset && (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_pc        = pc_q;
  assign o_next_pc   = pc_q + ADDRESS_WIDTH'(idx_q);
  assign o_opcode    = opcode_q;
  assign o_prefix    = prefix_q;
  assign o_fmt       = fmt_q;
  assign o_modrm     = modrm_q;
  assign o_sib       = sib_q;
  assign o_disp      = disp_q;
  assign o_imm       = imm_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed cases plus random
// instructions checked against a sequential byte-parser model.
module tb_instr_decode;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_res_valid;
  logic [119:0] i_instr;
  logic [3:0]   i_instr_len;
  logic [31:0]  i_pc;
  logic         o_dec_ready;
  logic         o_valid;
  logic         i_ex_ready;
  logic [31:0]  o_pc;
  logic [31:0]  o_next_pc;
  logic [7:0]   o_opcode;
  logic [7:0]   o_prefix;
  logic [1:0]   o_fmt;
  logic [7:0]   o_modrm;
  logic [7:0]   o_sib;
  logic [31:0]  o_disp;
  logic [31:0]  o_imm;
  logic         o_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          l;
    logic [7:0]  op;
    logic [7:0]  pfx;
    logic [1:0]  fmt;
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [31:0] imm;
    logic        err;
    logic        trunc;
  } dec_t;

  logic [7:0] pfx_list [11] = '{8'hF0, 8'hF3, 8'hF2, 8'h66, 8'h67, 8'h26, 8'h2E, 8'h36,
                                8'h3E, 8'h64, 8'h65};
  logic [7:0] op_list [18] = '{8'h90, 8'h05, 8'h04, 8'h83, 8'h81, 8'h80, 8'h89, 8'h8B,
                               8'h01, 8'hB8, 8'hB3, 8'h68, 8'h6A, 8'hE8, 8'hEB, 8'hC3,
                               8'h0F, 8'h50};

  always #5 clk = ~clk;

  instr_decode #(
    .ADDRESS_WIDTH  (32),
    .MAX_INSTR_WIDTH(120)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_res_valid(i_res_valid),
    .i_instr    (i_instr),
    .i_instr_len(i_instr_len),
    .i_pc       (i_pc),
    .o_dec_ready(o_dec_ready),
    .o_valid    (o_valid),
    .i_ex_ready (i_ex_ready),
    .o_pc       (o_pc),
    .o_next_pc  (o_next_pc),
    .o_opcode   (o_opcode),
    .o_prefix   (o_prefix),
    .o_fmt      (o_fmt),
    .o_modrm    (o_modrm),
    .o_sib      (o_sib),
    .o_disp     (o_disp),
    .o_imm      (o_imm),
    .o_err      (o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the byte string the way the instruction format reads.
  function automatic dec_t model(input logic [119:0] ins, input int len);
    dec_t e;
    int i, dl, il, imm32;
    logic [7:0] b;
    logic [1:0] md;
    logic [2:0] rm;
    bit found, need_modrm, bad;
    e.l = 0; e.op = 0; e.pfx = 0; e.fmt = 0; e.modrm = 0; e.sib = 0;
    e.disp = 0; e.imm = 0; e.err = 0; e.trunc = 0;
    i = 0; found = 0;
    while (!found) begin
      if (i >= len) begin e.trunc = 1; e.err = 1; e.l = i; return e; end
      b = ins[i*8 +: 8]; i++;
      case (b)
        8'hF0: e.pfx[0] = 1;
        8'hF3: e.pfx[1] = 1;
        8'hF2: e.pfx[2] = 1;
        8'h66: e.pfx[3] = 1;
        8'h67: e.pfx[4] = 1;
        8'h26: e.pfx[7:5] = 1;
        8'h2E: e.pfx[7:5] = 2;
        8'h36: e.pfx[7:5] = 3;
        8'h3E: e.pfx[7:5] = 4;
        8'h64: e.pfx[7:5] = 5;
        8'h65: e.pfx[7:5] = 6;
        default: begin e.op = b; found = 1; end
      endcase
    end
    imm32 = e.pfx[3] ? 2 : 4;
    il = 0; dl = 0; need_modrm = 0; bad = 0;
    if (b <= 8'h3F) begin
      if (b[2:1] == 2'b10) il = b[0] ? imm32 : 1;
      else if (b[2:1] != 2'b11) need_modrm = 1;
    end else if (b inside {[8'h40:8'h5F], [8'h90:8'h97], 8'hC3, 8'hF4}) begin
      il = 0;
    end else if (b inside {[8'h88:8'h8B]}) begin
      need_modrm = 1;
    end else if (b == 8'h80 || b == 8'h83) begin
      need_modrm = 1; il = 1;
    end else if (b == 8'h81) begin
      need_modrm = 1; il = imm32;
    end else if (b inside {[8'hB0:8'hB7], 8'h6A, 8'hEB}) begin
      il = 1;
    end else if (b inside {[8'hB8:8'hBF], 8'h68, 8'hE8, 8'hE9}) begin
      il = imm32;
    end else begin
      bad = 1;
    end
    if (need_modrm) begin
      if (i >= len) begin e.trunc = 1; e.err = 1; e.l = i; return e; end
      b = ins[i*8 +: 8]; i++;
      e.modrm = b; e.fmt[0] = 1;
      md = b[7:6]; rm = b[2:0];
      if (md == 1) dl = 1;
      else if (md == 2 || (md == 0 && rm == 5)) dl = 4;
      if (md != 3 && rm == 4) begin
        if (i >= len) begin e.trunc = 1; e.err = 1; e.l = i; return e; end
        b = ins[i*8 +: 8]; i++;
        e.sib = b; e.fmt[1] = 1;
        if (md == 0 && b[2:0] == 5) dl = 4;
      end
    end
    for (int k = 0; k < dl; k++) begin
      if (i >= len) begin e.trunc = 1; e.err = 1; e.l = i; return e; end
      e.disp[8*k +: 8] = ins[i*8 +: 8]; i++;
    end
    if (dl == 1) e.disp = {{24{e.disp[7]}}, e.disp[7:0]};
    for (int k = 0; k < il; k++) begin
      if (i >= len) begin e.trunc = 1; e.err = 1; e.l = i; return e; end
      e.imm[8*k +: 8] = ins[i*8 +: 8]; i++;
    end
    if (il == 1) e.imm = {{24{e.imm[7]}}, e.imm[7:0]};
    if (il == 2) e.imm = {{16{e.imm[15]}}, e.imm[15:0]};
    e.l = i;
    e.err = bad || (i != len);
    return e;
  endfunction

  function automatic logic [119:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3,
                                      input logic [7:0] b4);
    logic [119:0] r;
    r = '0;
    r[39:0] = {b4, b3, b2, b1, b0};
    return r;
  endfunction

  // One full handshake: accept, count edges to o_valid, check, stall, release.
  task automatic run_one(input logic [119:0] ins, input logic [3:0] len,
                         input logic [31:0] pc, input int stall, output dec_t obs);
    dec_t e;
    int n;
    e = model(ins, int'(len));
    n = 0;
    while (o_dec_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("dec_ready_idle", o_dec_ready, 1);
    i_res_valid = 1'b1; i_instr = ins; i_instr_len = len; i_pc = pc;
    @(posedge clk); #1;
    // Inputs churn during decode and must be ignored.
    i_instr = {$urandom, $urandom, $urandom, $urandom};
    i_instr_len = 4'($urandom); i_pc = $urandom;
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      chk("dec_ready_busy", o_dec_ready, 0);
      @(posedge clk); #1; n++;
    end
    i_res_valid = 1'b0;
    obs.l = n; obs.op = o_opcode; obs.pfx = o_prefix; obs.fmt = o_fmt;
    obs.modrm = o_modrm; obs.sib = o_sib; obs.disp = o_disp; obs.imm = o_imm;
    obs.err = o_err; obs.trunc = 0;
    chk("latency", n, e.l);
    chk("err", o_err, e.err);
    chk("pc", o_pc, pc);
    chk("next_pc", o_next_pc, 32'(pc + e.l));
    chk("opcode", o_opcode, e.op);
    chk("prefix", o_prefix, e.pfx);
    if (!e.trunc) begin
      chk("fmt", o_fmt, e.fmt);
      chk("modrm", o_modrm, e.modrm);
      chk("sib", o_sib, e.sib);
      chk("disp", o_disp, e.disp);
      chk("imm", o_imm, e.imm);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_ready", o_dec_ready, 0);
      chk("hold_opcode", o_opcode, e.op);
      chk("hold_next_pc", o_next_pc, 32'(pc + e.l));
      chk("hold_err", o_err, e.err);
      if (!e.trunc) chk("hold_imm", o_imm, e.imm);
    end
    i_ex_ready = 1'b1;
    @(posedge clk); #1;
    i_ex_ready = 1'b0;
    chk("release_valid", o_valid, 0);
    chk("release_ready", o_dec_ready, 1);
  endtask

  initial begin
    dec_t obs, nat;
    logic [119:0] ins;
    logic [3:0]   len;
    int p;

    reset = 1'b0; i_res_valid = 1'b0; i_ex_ready = 1'b0;
    i_instr = '0; i_instr_len = 4'd0; i_pc = 32'h0;
    #3;
    chk("rst_ready", o_dec_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_fields", {o_pc, o_next_pc}, 64'h0);
    chk("rst_err", o_err, 0);
    #9 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", o_dec_ready, 1);

    run_one(mk(8'h90, 0, 0, 0, 0), 4'd1, 32'h100, 0, obs);
    chk("d1_lat", obs.l, 1);
    chk("d1_op", obs.op, 8'h90);
    chk("d1_fmt", obs.fmt, 0);
    chk("d1_err", obs.err, 0);

    run_one(mk(8'h05, 8'h78, 8'h56, 8'h34, 8'h12), 4'd5, 32'h2000, 1, obs);
    chk("d2_lat", obs.l, 5);
    chk("d2_imm", obs.imm, 32'h12345678);

    run_one(mk(8'h66, 8'h05, 8'h34, 8'h92, 0), 4'd4, 32'h3000, 0, obs);
    chk("d3_pfx3", obs.pfx[3], 1);
    chk("d3_imm", obs.imm, 32'hFFFF9234);
    chk("d3_err", obs.err, 0);

    run_one(mk(8'h83, 8'h44, 8'h24, 8'h08, 8'hFF), 4'd5, 32'h4000, 3, obs);
    chk("d4_fmt", obs.fmt, 2'b11);
    chk("d4_modrm", obs.modrm, 8'h44);
    chk("d4_sib", obs.sib, 8'h24);
    chk("d4_disp", obs.disp, 32'h8);
    chk("d4_imm", obs.imm, 32'hFFFFFFFF);

    run_one(mk(8'h0F, 8'h05, 0, 0, 0), 4'd2, 32'h5000, 0, obs);
    chk("d5_err", obs.err, 1);
    run_one(mk(8'h90, 0, 0, 0, 0), 4'd2, 32'h6000, 0, obs);
    chk("d6_err", obs.err, 1);

    // Reset pulse while gathering the imm32 of B8.
    i_res_valid = 1'b1; i_instr = mk(8'hB8, 8'h78, 8'h56, 8'h34, 8'h12);
    i_instr_len = 4'd5; i_pc = 32'h7000;
    @(posedge clk); #1;
    i_res_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", o_dec_ready, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_imm", o_imm, 0);
    chk("mid_rst_pc", {o_pc, o_next_pc}, 64'h0);
    chk("mid_rst_op", {o_opcode, o_prefix, o_modrm, o_sib}, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_valid", o_valid, 0);
    run_one(mk(8'h90, 0, 0, 0, 0), 4'd1, 32'h8000, 0, obs);
    chk("d7_op", obs.op, 8'h90);
    chk("d7_err", obs.err, 0);

    // Random instructions built from prefix/opcode pools with random tails.
    for (int t = 0; t < 80; t++) begin
      ins = {$urandom, $urandom, $urandom, $urandom};
      p = 0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        ins[p*8 +: 8] = pfx_list[$urandom_range(0, 10)];
        p++;
      end
      if ($urandom_range(0, 3) != 0) ins[p*8 +: 8] = op_list[$urandom_range(0, 17)];
      nat = model(ins, 15);
      if ($urandom_range(0, 3) != 0 && !nat.trunc) len = 4'(nat.l);
      else len = 4'($urandom_range(1, 15));
      run_one(ins, len, $urandom, $urandom_range(0, 3), obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
